// File: rtl/unified_buffer_stream.sv
// Word buffer with FIFO-slice, store-word and multi-word compute-burst access.
// Defining UB_BOUNDS_CHECK_EN rejects compute bursts that would run past the last word.
module unified_buffer_stream #(
    parameter int BUFFER_SIZE        = 1024,
    parameter int BUFFER_WORD_SIZE   = 16,
    parameter int FIFO_DATA_WIDTH    = 8,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int NUM_COMPUTE_LANES  = 64,
    parameter int STORE_DATA_WIDTH   = 16,
    localparam int ADDRESS_SIZE      = $clog2(BUFFER_SIZE),
    localparam int SECTIONS          = BUFFER_WORD_SIZE / FIFO_DATA_WIDTH,
    localparam int SECTION_W         = (SECTIONS > 1) ? $clog2(SECTIONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [1:0]                    cmd_op,
    input  logic [ADDRESS_SIZE-1:0]       cmd_addr,
    input  logic [SECTION_W-1:0]          cmd_section,
    input  logic [FIFO_DATA_WIDTH-1:0]    fifo_in,
    output logic [FIFO_DATA_WIDTH-1:0]    fifo_out,
    input  logic [STORE_DATA_WIDTH-1:0]   store_in,
    output logic [STORE_DATA_WIDTH-1:0]   store_out,
    input  logic [COMPUTE_DATA_WIDTH-1:0] compute_in  [NUM_COMPUTE_LANES-1:0],
    output logic [COMPUTE_DATA_WIDTH-1:0] compute_out [NUM_COMPUTE_LANES-1:0],
    output logic                          done,
    output logic                          err
);

    localparam int ITEMS_IN_SLOT = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH;
    localparam int BURST_WORDS   = NUM_COMPUTE_LANES / ITEMS_IN_SLOT;
    localparam int CNT_W         = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int LANE_BITS     = NUM_COMPUTE_LANES * COMPUTE_DATA_WIDTH;
    localparam logic [BUFFER_WORD_SIZE-1:0] STORE_MASK =
        BUFFER_WORD_SIZE'({STORE_DATA_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST_WR,
        ST_BURST_RD,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_FIFO  = 2'b00,
        OP_STORE = 2'b01,
        OP_BURST = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    logic [BUFFER_WORD_SIZE-1:0] mem_q [BUFFER_SIZE];

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ADDRESS_SIZE-1:0]     baddr_q, baddr_d;
    logic [LANE_BITS-1:0]        snap_q, snap_d;
    logic [LANE_BITS-1:0]        stage_q, stage_d;
    logic [LANE_BITS-1:0]        compute_out_q, compute_out_d;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_out_q, fifo_out_d;
    logic [STORE_DATA_WIDTH-1:0] store_out_q, store_out_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic                        mem_we;
    logic [ADDRESS_SIZE-1:0]     mem_waddr;
    logic [BUFFER_WORD_SIZE-1:0] mem_wdata;
    logic [ADDRESS_SIZE-1:0]     rd_addr;
    logic [BUFFER_WORD_SIZE-1:0] rd_word;
    logic [LANE_BITS-1:0]        compute_in_flat;
    logic                        burst_oob;
    int unsigned                 burst_lsb;
    int unsigned                 sec_lsb;

    always_comb begin
        compute_in_flat = '0;
        for (int unsigned i = 0; i < NUM_COMPUTE_LANES; i++) begin
            compute_in_flat[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] = compute_in[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_COMPUTE_LANES; i++) begin
            compute_out[i] = compute_out_q[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
        end
    end

`ifdef UB_BOUNDS_CHECK_EN
    assign burst_oob = (32'(cmd_addr) + 32'(BURST_WORDS)) > 32'(BUFFER_SIZE);
`else
    assign burst_oob = 1'b0;
`endif

    // One shared read port: burst address while streaming out, command address otherwise.
    assign rd_addr   = (state_q == ST_BURST_RD) ? baddr_q : cmd_addr;
    assign rd_word   = mem_q[rd_addr];
    assign burst_lsb = 32'(cnt_q) * 32'(BUFFER_WORD_SIZE);
    assign sec_lsb   = 32'(cmd_section) * 32'(FIFO_DATA_WIDTH);

    assign cmd_ready = (state_q == ST_IDLE);
    assign fifo_out  = fifo_out_q;
    assign store_out = store_out_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        baddr_d       = baddr_q;
        snap_d        = snap_q;
        stage_d       = stage_q;
        compute_out_d = compute_out_q;
        fifo_out_d    = fifo_out_q;
        store_out_d   = store_out_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = cmd_addr;
        mem_wdata     = rd_word;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_t'(cmd_op))
                        OP_FIFO: begin
                            done_d = 1'b1;
                            if (cmd_we) begin
                                mem_we = 1'b1;
                                mem_wdata[sec_lsb +: FIFO_DATA_WIDTH] = fifo_in;
                            end else begin
                                fifo_out_d = rd_word[sec_lsb +: FIFO_DATA_WIDTH];
                            end
                        end
                        OP_STORE: begin
                            done_d = 1'b1;
                            if (cmd_we) begin
                                mem_we    = 1'b1;
                                mem_wdata = (rd_word & ~STORE_MASK) |
                                            (BUFFER_WORD_SIZE'(store_in) & STORE_MASK);
                            end else begin
                                store_out_d = rd_word[STORE_DATA_WIDTH-1:0];
                            end
                        end
                        OP_BURST: begin
                            if (burst_oob) begin
                                err_d = 1'b1;
                            end else begin
                                baddr_d = cmd_addr;
                                cnt_d   = '0;
                                if (cmd_we) begin
                                    snap_d  = compute_in_flat;
                                    state_d = ST_BURST_WR;
                                end else begin
                                    state_d = ST_BURST_RD;
                                end
                            end
                        end
                        OP_RSVD: err_d = 1'b1;
                    endcase
                end
            end
            ST_BURST_WR: begin
                mem_we    = 1'b1;
                mem_waddr = baddr_q;
                mem_wdata = snap_q[burst_lsb +: BUFFER_WORD_SIZE];
                baddr_d   = baddr_q + ADDRESS_SIZE'(1);
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BURST_WORDS - 1)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end
            end
            ST_BURST_RD: begin
                stage_d[burst_lsb +: BUFFER_WORD_SIZE] = rd_word;
                baddr_d = baddr_q + ADDRESS_SIZE'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                // Final word goes straight into compute_out along with the staged ones.
                if (cnt_q == CNT_W'(BURST_WORDS - 1)) begin
                    compute_out_d = stage_d;
                    state_d       = ST_FINISH;
                    done_d        = 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            baddr_q       <= '0;
            snap_q        <= '0;
            stage_q       <= '0;
            compute_out_q <= '0;
            fifo_out_q    <= '0;
            store_out_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            baddr_q       <= baddr_d;
            snap_q        <= snap_d;
            stage_q       <= stage_d;
            compute_out_q <= compute_out_d;
            fifo_out_q    <= fifo_out_d;
            store_out_q   <= store_out_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_unified_buffer_stream.sv
// Directed self-checking bench for unified_buffer_stream at default parameters.
// Expectations follow UB_BOUNDS_CHECK_EN when the design is built with it.
module tb_unified_buffer_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [1:0] cmd_op;
    logic [9:0] cmd_addr;
    logic       cmd_section;
    logic [7:0] fifo_in;
    logic [7:0] fifo_out;
    logic [15:0] store_in;
    logic [15:0] store_out;
    logic [3:0] compute_in  [63:0];
    logic [3:0] compute_out [63:0];
    logic       done;
    logic       err;

    logic [3:0] exp_lanes [63:0];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unified_buffer_stream dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_section (cmd_section),
        .fifo_in     (fifo_in),
        .fifo_out    (fifo_out),
        .store_in    (store_in),
        .store_out   (store_out),
        .compute_in  (compute_in),
        .compute_out (compute_out),
        .done        (done),
        .err         (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic we, input logic [9:0] addr);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_we    = we;
        cmd_addr  = addr;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic store_wr(input logic [9:0] addr, input logic [15:0] data);
        store_in = data;
        issue(2'b01, 1'b1, addr);
    endtask

    task automatic store_rd_check(input string tag, input logic [9:0] addr, input logic [15:0] exp);
        issue(2'b01, 1'b0, addr);
        check(tag, store_out, exp);
    endtask

    function automatic logic [15:0] exp_word(input int k);
        return {exp_lanes[4*k+3], exp_lanes[4*k+2], exp_lanes[4*k+1], exp_lanes[4*k]};
    endfunction

    task automatic load_lanes();
        for (int i = 0; i < 64; i++) compute_in[i] = exp_lanes[i];
    endtask

    task automatic check_lanes(input string tag);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (compute_out[i] !== exp_lanes[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Called right after the accept edge; walks the 16 busy cycles and the done cycle.
    task automatic burst_track(input string tag, input logic we, input logic [3:0] hold1);
        int bad = 0;
        for (int c = 1; c <= 16; c++) begin
            if (cmd_ready !== 1'b0 || done !== 1'b0) bad++;
            if (!we && compute_out[1] !== hold1) bad++;
            if (we) for (int i = 0; i < 64; i++) compute_in[i] = 4'($urandom);
            step();
        end
        check({tag, "_busy"}, bad, 0);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_ready_fin"}, cmd_ready, 1'b0);
        step();
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_ready_idle"}, cmd_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
        cmd_section = 1'b0; fifo_in = '0; store_in = '0;
        for (int i = 0; i < 64; i++) begin compute_in[i] = '0; exp_lanes[i] = '0; end
        step();
        step();
        rst_n = 1'b1;
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_fifo_out", fifo_out, 8'h00);
        check("rst_store_out", store_out, 16'h0000);
        check_lanes("rst_compute_out");

        // FIFO slice writes compose a word, read back through the store port.
        cmd_section = 1'b0; fifo_in = 8'h34;
        issue(2'b00, 1'b1, 10'd5);
        check("fifo_wr_done", done, 1'b1);
        check("fifo_wr_ready", cmd_ready, 1'b1);
        cmd_section = 1'b1; fifo_in = 8'h12;
        issue(2'b00, 1'b1, 10'd5);
        store_rd_check("store_rd_5", 10'd5, 16'h1234);
        check("store_rd_done", done, 1'b1);
        step();
        check("idle_done_low", done, 1'b0);
        check("store_out_hold", store_out, 16'h1234);
        cmd_section = 1'b1;
        issue(2'b00, 1'b0, 10'd5);
        check("fifo_rd_sec1", fifo_out, 8'h12);
        cmd_section = 1'b0;
        issue(2'b00, 1'b0, 10'd5);
        check("fifo_rd_sec0", fifo_out, 8'h34);
        store_wr(10'd6, 16'hBEEF);
        cmd_section = 1'b1;
        issue(2'b00, 1'b0, 10'd6);
        check("raw_fifo_sec1", fifo_out, 8'hBE);

        // Compute burst write then read at 100, compute_in scrambled while busy.
        for (int i = 0; i < 64; i++) exp_lanes[i] = 4'(i % 16);
        load_lanes();
        issue(2'b10, 1'b1, 10'd100);
        burst_track("cwr100", 1'b1, 4'h0);
        issue(2'b10, 1'b0, 10'd100);
        burst_track("crd100", 1'b0, 4'h0);
        check_lanes("crd100_lanes");
        store_rd_check("w100", 10'd100, 16'h3210);
        store_rd_check("w101", 10'd101, 16'h7654);
        store_rd_check("w103", 10'd103, 16'hFEDC);
        store_rd_check("w115", 10'd115, 16'hFEDC);

        // Reserved op: error pulse only.
        issue(2'b11, 1'b1, 10'd100);
        check("rsvd_err", err, 1'b1);
        check("rsvd_done", done, 1'b0);
        check("rsvd_store_hold", store_out, 16'hFEDC);
        step();
        check("rsvd_err_clr", err, 1'b0);
        store_rd_check("rsvd_mem", 10'd100, 16'h3210);

        // Burst crossing the top of the buffer.
        store_wr(10'd1016, 16'h1111);
        store_wr(10'd0, 16'h2222);
        store_wr(10'd8, 16'hA5A5);
        store_wr(10'd1015, 16'h5A5A);
        for (int i = 0; i < 64; i++) exp_lanes[i] = 4'((i * 3 + 1) % 16);
        load_lanes();
        issue(2'b10, 1'b1, 10'd1016);
`ifdef UB_BOUNDS_CHECK_EN
        check("oob_wr_err", err, 1'b1);
        check("oob_wr_done", done, 1'b0);
        check("oob_wr_ready", cmd_ready, 1'b1);
        step();
        check("oob_err_clr", err, 1'b0);
        store_rd_check("oob_w1016", 10'd1016, 16'h1111);
        store_rd_check("oob_w0", 10'd0, 16'h2222);
        issue(2'b10, 1'b0, 10'd1016);
        check("oob_rd_err", err, 1'b1);
        for (int i = 0; i < 64; i++) exp_lanes[i] = 4'(i % 16);
        check_lanes("oob_rd_hold");
`else
        burst_track("cwr1016", 1'b1, 4'h0);
        store_rd_check("wrap_w1016", 10'd1016, exp_word(0));
        store_rd_check("wrap_w1023", 10'd1023, exp_word(7));
        store_rd_check("wrap_w0", 10'd0, exp_word(8));
        store_rd_check("wrap_w7", 10'd7, exp_word(15));
        store_rd_check("wrap_w8", 10'd8, 16'hA5A5);
        store_rd_check("wrap_w1015", 10'd1015, 16'h5A5A);
        issue(2'b10, 1'b0, 10'd1016);
        burst_track("crd1016", 1'b0, 4'h1);
        check_lanes("crd1016_lanes");
`endif

        // Reset during a write burst at burst cycle 8.
        store_wr(10'd210, 16'h1234);
        for (int i = 0; i < 64; i++) exp_lanes[i] = 4'h9;
        load_lanes();
        issue(2'b10, 1'b1, 10'd200);
        bad = 0;
        for (int c = 1; c <= 7; c++) begin
            if (done !== 1'b0) bad++;
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_no_done_pre", bad, 0);
        check("abort_done", done, 1'b0);
        check("abort_err", err, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_fifo_out", fifo_out, 8'h00);
        check("abort_store_out", store_out, 16'h0000);
        for (int i = 0; i < 64; i++) exp_lanes[i] = '0;
        check_lanes("abort_compute_out");
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (done !== 1'b0) bad++;
            step();
        end
        check("abort_no_done_post", bad, 0);
        store_rd_check("abort_w200", 10'd200, 16'h9999);
        store_rd_check("abort_w206", 10'd206, 16'h9999);
        store_rd_check("abort_w210", 10'd210, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unified_buffer_stream.md
UNIFIED_BUFFER_STREAM -- requirements
Module: unified_buffer_stream

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 1024: words in the buffer; power of two.
REQ-002 SHALL have parameter BUFFER_WORD_SIZE, default 16: bits per word.
REQ-003 SHALL have parameter FIFO_DATA_WIDTH, default 8: FIFO port width; must divide BUFFER_WORD_SIZE.
REQ-004 SHALL have parameter COMPUTE_DATA_WIDTH, default 4: bits per compute lane; must divide BUFFER_WORD_SIZE.
REQ-005 SHALL have parameter NUM_COMPUTE_LANES, default 64: lane count; NUM_COMPUTE_LANES*COMPUTE_DATA_WIDTH must be a multiple of BUFFER_WORD_SIZE.
REQ-006 SHALL have parameter STORE_DATA_WIDTH, default 16: store port width, at most BUFFER_WORD_SIZE.
REQ-007 SHALL derive ADDRESS_SIZE=$clog2(BUFFER_SIZE), SECTIONS=BUFFER_WORD_SIZE/FIFO_DATA_WIDTH, ITEMS_IN_SLOT=BUFFER_WORD_SIZE/COMPUTE_DATA_WIDTH, BURST_WORDS=NUM_COMPUTE_LANES/ITEMS_IN_SLOT.
REQ-008 Ports, in order:
 clk  in  1  clock, rising edge.
 rst_n  in  1  synchronous active-low reset.
 cmd_valid  in  1  command request.
 cmd_ready  out  1  block can accept a command.
 cmd_we  in  1  1 write, 0 read.
 cmd_op  in  2  00 FIFO, 01 store, 10 compute burst, 11 reserved.
 cmd_addr  in  ADDRESS_SIZE  base word address.
 cmd_section  in  max(1,$clog2(SECTIONS))  FIFO slice index, slice 0 = LSBs.
 fifo_in / fifo_out  in/out  FIFO_DATA_WIDTH  FIFO data.
 store_in / store_out  in/out  STORE_DATA_WIDTH  store data, word LSBs.
 compute_in / compute_out  in/out  unpacked [NUM_COMPUTE_LANES-1:0] of COMPUTE_DATA_WIDTH  lane data.
 done  out  1  one-cycle completion pulse.
 err  out  1  one-cycle rejection pulse.

Function
REQ-009 SHALL accept a command on a rising edge with cmd_valid && cmd_ready.
REQ-010 SHALL hold cmd_ready high in IDLE and low in BURST_WR, BURST_RD and FINISH.
REQ-011 FIFO/store ops SHALL complete in one cycle: write updates memory at the accept edge; read data and done valid the cycle after; cmd_ready stays high, back-to-back accepted every cycle.
REQ-012 FIFO write SHALL modify only slice cmd_section; store write only bits [STORE_DATA_WIDTH-1:0]; other bits unchanged.
REQ-013 Compute write SHALL snapshot compute_in at the accept edge, then in BURST_WR write word k (k=0..BURST_WORDS-1) at (cmd_addr+k) mod BUFFER_SIZE, one word per cycle; lane j+k*ITEMS_IN_SLOT sits at bits [COMPUTE_DATA_WIDTH*j +: COMPUTE_DATA_WIDTH].
REQ-014 Compute read SHALL read one word per cycle in BURST_RD into a staging register, load compute_out atomically on leaving BURST_RD; compute_out holds its old value until then.
REQ-015 FSM SHALL be IDLE -> BURST_WR|BURST_RD (BURST_WORDS cycles) -> FINISH (1 cycle, done=1) -> IDLE; done high exactly BURST_WORDS+1 cycles after the accept edge.
REQ-016 cmd_op=11 SHALL not touch memory or outputs other than err=1 the next cycle; done stays 0.
REQ-017 fifo_out, store_out, compute_out SHALL hold their last value when not updated.
REQ-018 Inputs other than cmd_* while busy SHALL be ignored; compute_in changes during BURST_WR SHALL not affect stored data.
REQ-019 Read and write to the same address on consecutive cycles SHALL return the newly written data.

Reset
REQ-020 With rst_n=0 at a rising edge: state IDLE, cmd_ready=1 the following cycle, done=0, err=0, fifo_out=0, store_out=0, all compute_out lanes=0, staging cleared.
REQ-021 Reset mid-burst SHALL abort the burst with no done; words already written remain; memory contents otherwise not reset.

Configuration
REQ-022 Macro UB_BOUNDS_CHECK_EN defined: a compute burst with cmd_addr+BURST_WORDS > BUFFER_SIZE SHALL be rejected, no memory access, err=1 the next cycle, FSM stays IDLE.
REQ-023 Macro UB_BOUNDS_CHECK_EN undefined: burst addresses SHALL wrap modulo BUFFER_SIZE; err only for cmd_op=11.

Verification (default parameters, BURST_WORDS=16)
REQ-024 FIFO write addr 5 sec 0 data 0x34, then sec 1 data 0x12; store read addr 5 -> store_out=0x1234, done 1 cycle later.
REQ-025 Compute write addr 100, lane i = i mod 16 -> done at cycle 17; compute read addr 100 -> compute_out lane i = i mod 16 at cycle 17, cmd_ready low cycles 1-17.
REQ-026 Compute write addr 1016 without UB_BOUNDS_CHECK_EN -> words 1016..1023 and 0..7 written; with it -> err=1 next cycle, memory unchanged.
REQ-027 rst_n low at burst cycle 8 -> done never pulses, outputs zero, cmd_ready high after reset release.
REQ-028 cmd_op=11 -> err pulse one cycle, done 0; toggling compute_in during BURST_WR does not alter stored words.
